// File: rtl/bj_phase_sequencer.sv
// rtl/bj_phase_sequencer.sv - blackjack game-phase sequencer with button conditioning and digit select
module bj_phase_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       next,
  input  logic       hit,
  input  logic       stand,
  input  logic       double,
  input  logic [3:0] bet_sw,
  input  logic [5:0] player_current_score,
  input  logic [5:0] player_new_card,
  input  logic [5:0] dealer_current_score,
  input  logic [4:0] current_coin,
  input  logic       win,
  input  logic       lose,
  input  logic       draw,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic [2:0] phase,
  output logic       doubled,
  output logic       led_win,
  output logic       led_lose,
  output logic       led_draw
);

  typedef enum logic [2:0] {
    S_BET    = 3'd0,
    S_DEAL   = 3'd1,
    S_PLAYER = 3'd2,
    S_DEALER = 3'd3,
    S_RESULT = 3'd4,
    S_OVER   = 3'd5
  } state_t;

  localparam logic [3:0] D_B     = 4'hA;
  localparam logic [3:0] D_D     = 4'hB;
  localparam logic [3:0] D_BLANK = 4'hD;

  // Tens/ones split of a 0..63 value; tens shows 0 rather than blank below 10.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 6'd10);
    ones = 4'(v % 6'd10);
    return {tens, ones};
  endfunction

  // Button lanes: bit 0 next, bit 1 hit, bit 2 stand, bit 3 double.
  logic [3:0] btn_raw;
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;
  logic [3:0] prev_q,  prev_d;
  logic [3:0] pulse_q, pulse_d;
  // A lane only arms after its synchronized level has been seen low, so a
  // button held through reset stays silent until released and pressed again.
  logic [3:0] armed_q, armed_d;
  logic [1:0] settle_q, settle_d;

  state_t     state_q, state_d;
  logic [2:0] hit_cnt_q, hit_cnt_d;
  logic       doubled_q, doubled_d;
  logic [2:0] led_q, led_d;        // {win, lose, draw}
  logic       res_seen_q, res_seen_d;
  logic [15:0] digit_q, digit_d;

  logic       p_next, p_hit, p_stand, p_dbl;
  logic [5:0] coin6;
  logic [5:0] bet6;
  logic [5:0] dbl_bet6;
  logic       settled;

  assign btn_raw  = {double, stand, hit, next};
  assign p_next   = pulse_q[0];
  assign p_hit    = pulse_q[1];
  assign p_stand  = pulse_q[2];
  assign p_dbl    = pulse_q[3];
  assign coin6    = {1'b0, current_coin};
  assign bet6     = {2'b00, bet_sw};
  assign dbl_bet6 = {1'b0, bet_sw, 1'b0};
  assign settled  = (settle_q == 2'd2);

  // Synchronizer chain, edge detect and post-reset arming for all four buttons.
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    pulse_d  = sync2_q & ~prev_q & armed_q;
    settle_d = settled ? settle_q : settle_q + 2'd1;
    armed_d  = armed_q | (settled ? ~sync2_q : 4'b0000);
  end

  // Game-phase next-state, hit counter, double flag and result LED latch.
  always_comb begin
    state_d    = state_q;
    hit_cnt_d  = hit_cnt_q;
    doubled_d  = doubled_q;
    led_d      = led_q;
    res_seen_d = (state_q == S_RESULT);
    case (state_q)
      S_BET: begin
        if (p_next && (bet_sw != 4'd0) && (bet6 <= coin6)) begin
          state_d = S_DEAL;
        end
      end
      S_DEAL: begin
        if (p_next) begin
          state_d = (win | lose | draw) ? S_RESULT : S_PLAYER;
        end
      end
      S_PLAYER: begin
        if (player_current_score > 6'd21) begin
          state_d = S_RESULT;
        end else if (p_stand) begin
          state_d = S_DEALER;
        end else if (p_dbl) begin
          if ((hit_cnt_q == 3'd0) && (dbl_bet6 <= coin6)) begin
            state_d   = S_DEALER;
            doubled_d = 1'b1;
          end
        end else if (p_hit) begin
          if (hit_cnt_q != 3'd7) begin
            hit_cnt_d = hit_cnt_q + 3'd1;
          end
        end
      end
      S_DEALER: begin
        if (p_next) begin
          state_d = S_RESULT;
        end
      end
      S_RESULT: begin
        // Outcome flags are captured on the first cycle spent in this state.
        if (!res_seen_q) begin
          led_d = {win, lose, draw};
        end
        if (p_next) begin
          led_d     = 3'b000;
          doubled_d = 1'b0;
          hit_cnt_d = 3'd0;
          state_d   = (current_coin == 5'd0) ? S_OVER : S_BET;
        end
      end
      S_OVER: begin
        state_d = S_OVER;
      end
      default: begin
        state_d = S_BET;
      end
    endcase
  end

  // Digit selection from the current phase and live game values.
  always_comb begin
    digit_d = {D_B, D_BLANK, 8'h00};
    case (state_q)
      S_BET:    digit_d = {D_B, D_BLANK, to_bcd(bet6)};
      S_DEAL:   digit_d = {D_D, D_BLANK, to_bcd(dealer_current_score)};
      S_PLAYER: digit_d = {to_bcd(player_current_score), to_bcd(player_new_card)};
      S_DEALER: digit_d = {D_D, D_BLANK, to_bcd(dealer_current_score)};
      S_RESULT: digit_d = {D_BLANK, D_BLANK, to_bcd(coin6)};
      S_OVER:   digit_d = {D_BLANK, D_BLANK, 8'h00};
      default:  digit_d = {D_B, D_BLANK, 8'h00};
    endcase
  end

  // All state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q    <= 4'b0000;
      sync2_q    <= 4'b0000;
      prev_q     <= 4'b0000;
      pulse_q    <= 4'b0000;
      armed_q    <= 4'b0000;
      settle_q   <= 2'd0;
      state_q    <= S_BET;
      hit_cnt_q  <= 3'd0;
      doubled_q  <= 1'b0;
      led_q      <= 3'b000;
      res_seen_q <= 1'b0;
      digit_q    <= {D_B, D_BLANK, 8'h00};
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      pulse_q    <= pulse_d;
      armed_q    <= armed_d;
      settle_q   <= settle_d;
      state_q    <= state_d;
      hit_cnt_q  <= hit_cnt_d;
      doubled_q  <= doubled_d;
      led_q      <= led_d;
      res_seen_q <= res_seen_d;
      digit_q    <= digit_d;
    end
  end

  assign digit3   = digit_q[15:12];
  assign digit2   = digit_q[11:8];
  assign digit1   = digit_q[7:4];
  assign digit0   = digit_q[3:0];
  assign phase    = state_q;
  assign doubled  = doubled_q;
  assign led_win  = led_q[2];
  assign led_lose = led_q[1];
  assign led_draw = led_q[0];

endmodule
